// File: rtl/ysyx_23060201_lsu_pkg.sv
// Shared LSU definitions: RV32 funct3 codes, FSM states
// and the fixed word read mask.
package ysyx_23060201_defines;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [7:0] RMASK_WORD = 8'h0F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_e;

  function automatic logic f3_illegal(
    input logic       is_store,
    input logic [2:0] f3
  );
    if (is_store) return f3 > F3_SW;
    return (f3 == 3'b011) || (f3 == 3'b110) ||
           (f3 == 3'b111);
  endfunction

endpackage

// File: rtl/ysyx_23060201_lsu_if.sv
// Execute/write-back handshakes plus data-memory port
// bundled for the LSU.
interface ysyx_23060201_lsu_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_is_store;
  logic [2:0]            in_funct3;
  logic [ADDR_WIDTH-1:0] in_addr;
  logic [DATA_WIDTH-1:0] in_wdata;
  logic [4:0]            in_rd;

  logic                  mem_wen;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [7:0]            mem_wmask;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_ren;
  logic [ADDR_WIDTH-1:0] mem_raddr;
  logic [7:0]            mem_rmask;
  logic [DATA_WIDTH-1:0] mem_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_rdata;
  logic [4:0]            out_rd;
  logic                  out_fault;

  modport slave (
    input  in_valid, in_is_store, in_funct3,
    input  in_addr, in_wdata, in_rd,
    output in_ready,
    output mem_wen, mem_waddr, mem_wmask, mem_wdata,
    output mem_ren, mem_raddr, mem_rmask,
    input  mem_rdata,
    output out_valid, out_rdata, out_rd, out_fault,
    input  out_ready
  );

  modport master (
    output in_valid, in_is_store, in_funct3,
    output in_addr, in_wdata, in_rd,
    input  in_ready,
    input  mem_wen, mem_waddr, mem_wmask, mem_wdata,
    input  mem_ren, mem_raddr, mem_rmask,
    output mem_rdata,
    input  out_valid, out_rdata, out_rd, out_fault,
    output out_ready
  );
endinterface

// File: rtl/ysyx_23060201_lsu_align.sv
// Byte-lane alignment: store mask/shift, misalign check,
// load realign and sign/zero extension.
module ysyx_23060201_lsu_align
  import ysyx_23060201_defines::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [7:0]  wmask,
  output logic [31:0] wdata_sh,
  output logic        misalign,
  output logic [31:0] rdata
);

  logic [4:0]  sh;
  logic [3:0]  base;
  logic [31:0] rsh;

  assign sh  = {off, 3'b000};
  assign rsh = rword >> sh;

  always_comb begin
    base = 4'hF;
    unique case (funct3[1:0])
      2'b00:   base = 4'h1;
      2'b01:   base = 4'h3;
      default: base = 4'hF;
    endcase
  end

  assign wmask    = {4'h0, base << off};
  assign wdata_sh = wdata << sh;

  assign misalign =
    ((funct3[1:0] == 2'b01) && off[0]) ||
    ((funct3[1:0] == 2'b10) && (off != 2'b00));

  always_comb begin
    rdata = '0;
    unique case (funct3)
      F3_LB:   rdata = {{24{rsh[7]}}, rsh[7:0]};
      F3_LH:   rdata = {{16{rsh[15]}}, rsh[15:0]};
      F3_LW:   rdata = rsh;
      F3_LBU:  rdata = {24'h0, rsh[7:0]};
      F3_LHU:  rdata = {16'h0, rsh[15:0]};
      default: rdata = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: one request at a time, IDLE/ACCESS/RESP
// sequencing between execute, data memory and write-back.
module ysyx_23060201_lsu
  import ysyx_23060201_defines::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  ysyx_23060201_lsu_if.slave bus
);

  lsu_state_e state_q, state_d;

  logic                  st_q;
  logic [2:0]            f3_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [4:0]            rd_q;
  logic                  fault_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  idle, accept, fault_in;
  logic [2:0]            a_f3;
  logic [1:0]            a_off;
  logic [7:0]            a_wmask;
  logic [31:0]           a_wdata, a_rdata;
  logic                  a_mis;
  logic [ADDR_WIDTH-1:0] word_addr;

  assign idle   = (state_q == ST_IDLE);
  assign accept = idle && bus.in_valid;

  // Legality is judged on the live request while idle,
  // lane math on the latched one afterwards.
  assign a_f3  = idle ? bus.in_funct3  : f3_q;
  assign a_off = idle ? bus.in_addr[1:0] : addr_q[1:0];

  ysyx_23060201_lsu_align u_align (
    .funct3   (a_f3),
    .off      (a_off),
    .wdata    (wdata_q),
    .rword    (bus.mem_rdata),
    .wmask    (a_wmask),
    .wdata_sh (a_wdata),
    .misalign (a_mis),
    .rdata    (a_rdata)
  );

  assign fault_in = a_mis ||
    f3_illegal(bus.in_is_store, bus.in_funct3);
  assign word_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      st_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      fault_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        st_q    <= bus.in_is_store;
        f3_q    <= bus.in_funct3;
        addr_q  <= bus.in_addr;
        wdata_q <= bus.in_wdata;
        rd_q    <= bus.in_rd;
        fault_q <= fault_in;
        rdata_q <= '0;
      end
      if (state_q == ST_ACCESS && !st_q)
        rdata_q <= a_rdata;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:
        if (bus.in_valid)
          state_d = fault_in ? ST_RESP : ST_ACCESS;
      ST_ACCESS: state_d = ST_RESP;
      ST_RESP:
        if (bus.out_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = idle;
    bus.mem_wen   = 1'b0;
    bus.mem_waddr = '0;
    bus.mem_wmask = '0;
    bus.mem_wdata = '0;
    bus.mem_ren   = 1'b0;
    bus.mem_raddr = '0;
    bus.mem_rmask = '0;
    bus.out_valid = 1'b0;
    bus.out_rdata = '0;
    bus.out_rd    = '0;
    bus.out_fault = 1'b0;
    if (state_q == ST_ACCESS) begin
      if (st_q) begin
        bus.mem_wen   = 1'b1;
        bus.mem_waddr = word_addr;
        bus.mem_wmask = a_wmask;
        bus.mem_wdata = a_wdata;
      end else begin
        bus.mem_ren   = 1'b1;
        bus.mem_raddr = word_addr;
        bus.mem_rmask = RMASK_WORD;
      end
    end
    if (state_q == ST_RESP) begin
      bus.out_valid = 1'b1;
      bus.out_rdata = rdata_q;
      bus.out_rd    = st_q ? 5'd0 : rd_q;
      bus.out_fault = fault_q;
    end
  end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed table-driven bench for the LSU plus
// backpressure and reset-abort sequences.
module tb_ysyx_23060201_lsu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ysyx_23060201_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ysyx_23060201_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rword;
    logic [4:0]  rd;
    logic        fault;
    logic [31:0] maddr;
    logic [7:0]  mask;
    logic [31:0] mwdata;
    logic [31:0] rdata;
    logic [4:0]  erd;
  } vec_t;

  vec_t v [14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t x);
    bus.in_is_store = x.st;
    bus.in_funct3   = x.f3;
    bus.in_addr     = x.addr;
    bus.in_wdata    = x.wdata;
    bus.in_rd       = x.rd;
    bus.mem_rdata   = x.rword;
  endtask

  initial begin
    // st f3 addr wdata rword rd | fault maddr mask mwdata rdata erd
    v[0]  = '{1, 3'b010, 32'h80000104, 32'hDEADBEEF, 32'h0, 5'd5,
              0, 32'h80000104, 8'h0F, 32'hDEADBEEF, 32'h0, 5'd0};
    v[1]  = '{1, 3'b000, 32'h80000103, 32'h000000A5, 32'h0, 5'd1,
              0, 32'h80000100, 8'h08, 32'hA5000000, 32'h0, 5'd0};
    v[2]  = '{1, 3'b001, 32'h80000102, 32'h00001234, 32'h0, 5'd2,
              0, 32'h80000100, 8'h0C, 32'h12340000, 32'h0, 5'd0};
    v[3]  = '{0, 3'b000, 32'h80000102, 32'h0, 32'h12F03456, 5'd7,
              0, 32'h80000100, 8'h0F, 32'h0, 32'hFFFFFFF0, 5'd7};
    v[4]  = '{0, 3'b100, 32'h80000102, 32'h0, 32'h12F03456, 5'd8,
              0, 32'h80000100, 8'h0F, 32'h0, 32'h000000F0, 5'd8};
    v[5]  = '{0, 3'b001, 32'h80000106, 32'h0, 32'h80010000, 5'd9,
              0, 32'h80000104, 8'h0F, 32'h0, 32'hFFFF8001, 5'd9};
    v[6]  = '{0, 3'b101, 32'h80000106, 32'h0, 32'h80010000, 5'd10,
              0, 32'h80000104, 8'h0F, 32'h0, 32'h00008001, 5'd10};
    v[7]  = '{0, 3'b010, 32'h80000108, 32'h0, 32'hCAFEF00D, 5'd31,
              0, 32'h80000108, 8'h0F, 32'h0, 32'hCAFEF00D, 5'd31};
    v[8]  = '{0, 3'b001, 32'h80000102, 32'h0, 32'h7FFF0000, 5'd4,
              0, 32'h80000100, 8'h0F, 32'h0, 32'h00007FFF, 5'd4};
    v[9]  = '{0, 3'b000, 32'h80000101, 32'h0, 32'h00008000, 5'd6,
              0, 32'h80000100, 8'h0F, 32'h0, 32'hFFFFFF80, 5'd6};
    v[10] = '{0, 3'b010, 32'h80000101, 32'h0, 32'h11111111, 5'd0,
              1, 32'h0, 8'h0, 32'h0, 32'h0, 5'd0};
    v[11] = '{1, 3'b001, 32'h80000101, 32'h5555, 32'h0, 5'd0,
              1, 32'h0, 8'h0, 32'h0, 32'h0, 5'd0};
    v[12] = '{1, 3'b011, 32'h80000100, 32'h5555, 32'h0, 5'd0,
              1, 32'h0, 8'h0, 32'h0, 32'h0, 5'd0};
    v[13] = '{0, 3'b110, 32'h80000100, 32'h0, 32'h22222222, 5'd0,
              1, 32'h0, 8'h0, 32'h0, 32'h0, 5'd0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    drive(v[0]);

    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst wen", 32'(bus.mem_wen), 32'd0);
    chk("rst ren", 32'(bus.mem_ren), 32'd0);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_fault", 32'(bus.out_fault), 32'd0);
    chk("rst out_rdata", bus.out_rdata, 32'd0);
    chk("rst out_rd", 32'(bus.out_rd), 32'd0);
    chk("rst waddr", bus.mem_waddr, 32'd0);
    chk("rst wmask", 32'(bus.mem_wmask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(v[i]);
      bus.in_valid = 1'b1;
      chk($sformatf("v%0d in_ready", i), 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (!v[i].fault) begin
        chk($sformatf("v%0d wen", i), 32'(bus.mem_wen), 32'(v[i].st));
        chk($sformatf("v%0d ren", i), 32'(bus.mem_ren), 32'(!v[i].st));
        chk($sformatf("v%0d waddr", i), bus.mem_waddr,
            v[i].st ? v[i].maddr : 32'h0);
        chk($sformatf("v%0d raddr", i), bus.mem_raddr,
            v[i].st ? 32'h0 : v[i].maddr);
        chk($sformatf("v%0d wmask", i), 32'(bus.mem_wmask),
            v[i].st ? 32'(v[i].mask) : 32'h0);
        chk($sformatf("v%0d rmask", i), 32'(bus.mem_rmask),
            v[i].st ? 32'h0 : 32'h0F);
        chk($sformatf("v%0d wdata", i), bus.mem_wdata, v[i].mwdata);
        chk($sformatf("v%0d early_valid", i), 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
      end else begin
        chk($sformatf("v%0d f_wen", i), 32'(bus.mem_wen), 32'd0);
        chk($sformatf("v%0d f_ren", i), 32'(bus.mem_ren), 32'd0);
      end
      chk($sformatf("v%0d out_valid", i), 32'(bus.out_valid), 32'd1);
      chk($sformatf("v%0d out_fault", i), 32'(bus.out_fault),
          32'(v[i].fault));
      chk($sformatf("v%0d out_rdata", i), bus.out_rdata, v[i].rdata);
      chk($sformatf("v%0d out_rd", i), 32'(bus.out_rd), 32'(v[i].erd));
      chk($sformatf("v%0d busy", i), 32'(bus.in_ready), 32'd0);
      chk($sformatf("v%0d resp_wen", i), 32'(bus.mem_wen), 32'd0);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk($sformatf("v%0d done_valid", i), 32'(bus.out_valid), 32'd0);
      chk($sformatf("v%0d done_ready", i), 32'(bus.in_ready), 32'd1);
    end

    // Backpressure on a load result, with a stray request in RESP
    @(negedge clk);
    drive(v[3]);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(posedge clk);
    #1;
    drive(v[0]);
    bus.in_valid = 1'b1;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bp%0d valid", c), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp%0d rdata", c), bus.out_rdata, 32'hFFFFFFF0);
      chk($sformatf("bp%0d rd", c), 32'(bus.out_rd), 32'd7);
      chk($sformatf("bp%0d in_ready", c), 32'(bus.in_ready), 32'd0);
      chk($sformatf("bp%0d strobes", c),
          32'({bus.mem_wen, bus.mem_ren}), 32'd0);
      @(posedge clk);
      #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("bp idle", 32'(bus.in_ready), 32'd1);
    chk("bp valid_low", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("bp no_strobe", 32'({bus.mem_wen, bus.mem_ren}), 32'd0);

    // Reset during ACCESS aborts the load
    @(negedge clk);
    drive(v[7]);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("ra access_ren", 32'(bus.mem_ren), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("ra in_ready", 32'(bus.in_ready), 32'd1);
    chk("ra strobes", 32'({bus.mem_wen, bus.mem_ren}), 32'd0);
    chk("ra out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("ra late_strobes", 32'({bus.mem_wen, bus.mem_ren}), 32'd0);
    chk("ra late_valid", 32'(bus.out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
